// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Purpose : shared constants and types for the registered RV32 decode stage
//           (id_stage_pipe) and its hazard scoreboard (id_scoreboard).
// Contents: major opcodes, funct3/funct7 values, operation codes (oh),
//           instruction format enum, scoreboard entry type.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package id_pkg;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [4:0] OH_NOP   = 5'd0;
   localparam logic [4:0] OH_ADDI  = 5'd1;
   localparam logic [4:0] OH_ADD   = 5'd2;
   localparam logic [4:0] OH_SUB   = 5'd3;
   localparam logic [4:0] OH_BNE   = 5'd4;
   localparam logic [4:0] OH_BEQ   = 5'd5;
   localparam logic [4:0] OH_JAL   = 5'd6;
   localparam logic [4:0] OH_LUI   = 5'd7;
   localparam logic [4:0] OH_ANDI  = 5'd8;
   localparam logic [4:0] OH_ORI   = 5'd9;
   localparam logic [4:0] OH_XORI  = 5'd10;
   localparam logic [4:0] OH_AND   = 5'd11;
   localparam logic [4:0] OH_OR    = 5'd12;
   localparam logic [4:0] OH_XOR   = 5'd13;
   localparam logic [4:0] OH_AUIPC = 5'd14;

   // FMT_NONE doubles as "undecodable"
   typedef enum logic [2:0] {
      FMT_NONE, FMT_I, FMT_R, FMT_B, FMT_U, FMT_J
   } fmt_e;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
   } sb_entry_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
// Purpose : bundles the if_id-side handshake, regfile read port and ex-side
//           output register of the decode stage.
// Modports: slave  - the decode stage itself.
//           master - the surrounding pipeline (if_id, regfile, ex).
// Signals : in_valid/in_ready/ins/ins_addr/flush, rs1/rs2 addr+data,
//           out_valid/out_ready, op1, op2, imm, ins2ex, pc_out, rd_addr,
//           rd_wen, oh, illegal.
// Macro   : ID_FWD_EN adds wb_wen, wb_rd, wb_data (write-back forwarding).
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
   parameter int XLEN = 32,
   parameter int OH_W = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     ins;
   logic [XLEN-1:0] ins_addr;
   logic            flush;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [XLEN-1:0] imm;
   logic [31:0]     ins2ex;
   logic [XLEN-1:0] pc_out;
   logic [4:0]      rd_addr;
   logic            rd_wen;
   logic [OH_W-1:0] oh;
   logic            illegal;
`ifdef ID_FWD_EN
   logic            wb_wen;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
`endif

   modport slave (
      input  in_valid, ins, ins_addr, flush, rs1_data, rs2_data, out_ready,
`ifdef ID_FWD_EN
      input  wb_wen, wb_rd, wb_data,
`endif
      output in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, imm,
             ins2ex, pc_out, rd_addr, rd_wen, oh, illegal
   );

   modport master (
      output in_valid, ins, ins_addr, flush, rs1_data, rs2_data, out_ready,
`ifdef ID_FWD_EN
      output wb_wen, wb_rd, wb_data,
`endif
      input  in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, imm,
             ins2ex, pc_out, rd_addr, rd_wen, oh, illegal
   );
endinterface

// File: rtl/id_stage_pipe_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
// Purpose : tracks destination registers of ops between the decode output
//           register and regfile write-back, and flags RAW hazards.
// Ports   : clk, rst (async, active-high)
//           shift   - advance all slots toward the oldest (ex took an op slot)
//           push    - a register-writing op is accepted this cycle
//           push_rd - its destination
//           rs1/rs2 - source registers of the instruction being decoded
//                     (already zero when the source is unused)
//           hazard  - a source matches a checked in-flight destination
// Macro   : ID_FWD_EN excludes the oldest slot, which write-back forwards.
// ---------------------------------------------------------------------------
module id_scoreboard
   import id_pkg::*;
#(
   parameter int HAZ_DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       shift,
   input  logic       push,
   input  logic [4:0] push_rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   output logic       hazard
);
`ifdef ID_FWD_EN
   localparam int CHK = HAZ_DEPTH - 1;
`else
   localparam int CHK = HAZ_DEPTH;
`endif

   sb_entry_t slots [HAZ_DEPTH];
   sb_entry_t new_entry;

   // non-writing ops enter as a bubble so slot age stays aligned with stages
   always_comb begin
      new_entry.v  = push;
      new_entry.rd = push ? push_rd : 5'd0;
   end

   // ---- scoreboard slots: slot 0 youngest, slot HAZ_DEPTH-1 oldest ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HAZ_DEPTH; i++) slots[i] <= '0;
      end else if (shift) begin
         slots[0] <= new_entry;
         for (int i = 1; i < HAZ_DEPTH; i++) slots[i] <= slots[i-1];
      end else if (push) begin
         // output register was empty, so slot 0 carries no live op
         slots[0] <= new_entry;
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < CHK; i++) begin
         if (slots[i].v &&
             ((rs1 != 5'd0 && rs1 == slots[i].rd) ||
              (rs2 != 5'd0 && rs2 == slots[i].rd)))
            hazard = 1'b1;
      end
   end
endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Purpose : registered, handshaked RV32 decode stage between if_id and ex.
//           Decodes ins, reads the regfile (same cycle), stalls on RAW
//           hazards and registers the op into the ex-side output register.
// Ports   : clk, rst (async, active-high), bus (id_stage_pipe_if.slave):
//           in_valid/in_ready/ins/ins_addr/flush from if_id, rs1/rs2 regfile
//           read port, out_valid/out_ready + op1/op2/imm/ins2ex/pc_out/
//           rd_addr/rd_wen/oh/illegal toward ex.
// Macro   : ID_FWD_EN enables write-back forwarding into op1/op2 and
//           shortens the hazard window by one slot.
// ---------------------------------------------------------------------------
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int OH_W      = 5,
   parameter int HAZ_DEPTH = 3
) (
   input logic           clk,
   input logic           rst,
   id_stage_pipe_if.slave bus
);
   logic [31:0]            ins;
   logic [6:0]             opc, f7;
   logic [2:0]             f3;
   fmt_e                   fmt;
   logic [4:0]             code;
   logic signed [XLEN-1:0] imm_d;
   logic                   use1, use2;
   logic [4:0]             rs1_a, rs2_a, rd_d;
   logic [XLEN-1:0]        src1, src2, op1_d, op2_d;
   logic                   wen_d, ill_d, hazard, in_ready, fire;

   logic                   vld_p1;
   logic [XLEN-1:0]        op1_p1, op2_p1, imm_p1, pc_p1;
   logic [31:0]            ins_p1;
   logic [4:0]             rd_p1;
   logic                   wen_p1, ill_p1;
   logic [OH_W-1:0]        oh_p1;

   assign ins = bus.ins;
   assign opc = ins[6:0];
   assign f3  = ins[14:12];
   assign f7  = ins[31:25];

   // ---- stage p0: decode ----
   always_comb begin
      fmt  = FMT_NONE;
      code = OH_NOP;
      case (opc)
         OPC_OPIMM: begin
            fmt = FMT_I;
            case (f3)
               F3_ADD:  code = OH_ADDI;
               F3_AND:  code = OH_ANDI;
               F3_OR:   code = OH_ORI;
               F3_XOR:  code = OH_XORI;
               default: fmt  = FMT_NONE;
            endcase
         end
         OPC_OP: begin
            fmt = FMT_R;
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  code = OH_ADD;
                  F3_AND:  code = OH_AND;
                  F3_OR:   code = OH_OR;
                  F3_XOR:  code = OH_XOR;
                  default: fmt  = FMT_NONE;
               endcase
            end else if (f7 == F7_SUB && f3 == F3_ADD) begin
               code = OH_SUB;
            end else begin
               fmt = FMT_NONE;
            end
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            case (f3)
               F3_BEQ:  code = OH_BEQ;
               F3_BNE:  code = OH_BNE;
               default: fmt  = FMT_NONE;
            endcase
         end
         OPC_LUI:   begin fmt = FMT_U; code = OH_LUI;   end
         OPC_AUIPC: begin fmt = FMT_U; code = OH_AUIPC; end
         OPC_JAL:   begin fmt = FMT_J; code = OH_JAL;   end
         default: ;
      endcase
   end

   always_comb begin
      imm_d = '0;
      use1  = 1'b0;
      use2  = 1'b0;
      case (fmt)
         FMT_I: begin
            imm_d = XLEN'($signed(ins[31:20]));
            use1  = 1'b1;
         end
         FMT_R: begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         FMT_B: begin
            imm_d = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            use1  = 1'b1;
            use2  = 1'b1;
         end
         FMT_U:   imm_d = XLEN'($signed({ins[31:12], 12'h000}));
         FMT_J:   imm_d = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default: ;
      endcase
   end

   // unused sources read address 0 so they can never raise a hazard
   assign rs1_a = use1 ? ins[19:15] : 5'd0;
   assign rs2_a = use2 ? ins[24:20] : 5'd0;
   assign bus.rs1_addr = rs1_a;
   assign bus.rs2_addr = rs2_a;

   always_comb begin
      src1 = bus.rs1_data;
      src2 = bus.rs2_data;
`ifdef ID_FWD_EN
      if (bus.wb_wen && bus.wb_rd != 5'd0 && bus.wb_rd == rs1_a) src1 = bus.wb_data;
      if (bus.wb_wen && bus.wb_rd != 5'd0 && bus.wb_rd == rs2_a) src2 = bus.wb_data;
`endif
   end

   always_comb begin
      op1_d = '0;
      op2_d = '0;
      case (fmt)
         FMT_I:        begin op1_d = src1; op2_d = imm_d; end
         FMT_R, FMT_B: begin op1_d = src1; op2_d = src2;  end
         FMT_U:        begin op1_d = (code == OH_AUIPC) ? bus.ins_addr : '0; op2_d = imm_d; end
         FMT_J:        begin op1_d = bus.ins_addr; op2_d = imm_d; end
         default: ;
      endcase
   end

   assign rd_d  = (fmt == FMT_B || fmt == FMT_NONE) ? 5'd0 : ins[11:7];
   assign wen_d = (rd_d != 5'd0);
   assign ill_d = (fmt == FMT_NONE);

   id_scoreboard #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
      .clk     (clk),
      .rst     (rst),
      .shift   (bus.out_ready),
      .push    (fire & wen_d),
      .push_rd (rd_d),
      .rs1     (rs1_a),
      .rs2     (rs2_a),
      .hazard  (hazard)
   );

   assign in_ready     = (~vld_p1 | bus.out_ready) & ~hazard & ~bus.flush;
   assign fire         = bus.in_valid & in_ready;
   assign bus.in_ready = in_ready;

   // ---- stage p1: ex-side output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         op1_p1 <= '0;
         op2_p1 <= '0;
         imm_p1 <= '0;
         pc_p1  <= '0;
         ins_p1 <= '0;
         rd_p1  <= '0;
         wen_p1 <= 1'b0;
         ill_p1 <= 1'b0;
         oh_p1  <= '0;
      end else begin
         if (bus.flush)          vld_p1 <= 1'b0;
         else if (fire)          vld_p1 <= 1'b1;
         else if (bus.out_ready) vld_p1 <= 1'b0;
         if (fire) begin
            op1_p1 <= op1_d;
            op2_p1 <= op2_d;
            imm_p1 <= imm_d;
            pc_p1  <= bus.ins_addr;
            ins_p1 <= ins;
            rd_p1  <= rd_d;
            wen_p1 <= wen_d;
            ill_p1 <= ill_d;
            oh_p1  <= OH_W'(code);
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.op1       = op1_p1;
   assign bus.op2       = op2_p1;
   assign bus.imm       = imm_p1;
   assign bus.pc_out    = pc_p1;
   assign bus.ins2ex    = ins_p1;
   assign bus.rd_addr   = rd_p1;
   assign bus.rd_wen    = wen_p1;
   assign bus.illegal   = ill_p1;
   assign bus.oh        = oh_p1;
endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed scenarios followed by randomized traffic. The driver predicts
// in_ready from a mnemonic-level model and queues the expected op on every
// accepted instruction; an independent monitor compares the output register
// whenever ex takes an op.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;
   localparam int XLEN      = 32;
   localparam int OH_W      = 5;
   localparam int HAZ_DEPTH = 3;
`ifdef ID_FWD_EN
   localparam int CHK = HAZ_DEPTH - 1;
`else
   localparam int CHK = HAZ_DEPTH;
`endif

   typedef struct packed {
      logic [31:0] op1, op2, imm, ins, pc;
      logic [4:0]  rd;
      logic        wen;
      logic [4:0]  oh;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_stage_pipe_if #(.XLEN(XLEN), .OH_W(OH_W)) bus ();
   id_stage_pipe #(.XLEN(XLEN), .OH_W(OH_W), .HAZ_DEPTH(HAZ_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] rf [32];
   assign bus.rs1_data = rf[bus.rs1_addr];
   assign bus.rs2_data = rf[bus.rs2_addr];
`ifdef ID_FWD_EN
   assign bus.wb_wen  = 1'b0;
   assign bus.wb_rd   = 5'd0;
   assign bus.wb_data = '0;
`endif

   int   n_pass = 0;
   int   n_chk  = 0;
   exp_t q[$];
   logic [4:0] msb [HAZ_DEPTH];   // in-flight destinations, 0 = empty
   logic mv = 1'b0;               // model: output register occupied

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Mnemonic table: 1 ADDI 2 ADD 3 SUB 4 BNE 5 BEQ 6 JAL 7 LUI 8 ANDI
   // 9 ORI 10 XORI 11 AND 12 OR 13 XOR 14 AUIPC, 0 = illegal
   function automatic void ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      output exp_t e, output logic [4:0] s1,
                                      output logic [4:0] s2);
      int m;
      logic [31:0] imm;
      logic useA, useB;
      m = 0;
      if (i[6:0] == 7'h13)
         m = (i[14:12] == 0) ? 1 : (i[14:12] == 7) ? 8 : (i[14:12] == 6) ? 9 :
             (i[14:12] == 4) ? 10 : 0;
      else if (i[6:0] == 7'h33 && i[31:25] == 7'h00)
         m = (i[14:12] == 0) ? 2 : (i[14:12] == 7) ? 11 : (i[14:12] == 6) ? 12 :
             (i[14:12] == 4) ? 13 : 0;
      else if (i[6:0] == 7'h33 && i[31:25] == 7'h20 && i[14:12] == 0) m = 3;
      else if (i[6:0] == 7'h63) m = (i[14:12] == 0) ? 5 : (i[14:12] == 1) ? 4 : 0;
      else if (i[6:0] == 7'h6f) m = 6;
      else if (i[6:0] == 7'h37) m = 7;
      else if (i[6:0] == 7'h17) m = 14;

      imm = 0;
      if (m inside {1, 8, 9, 10}) imm = 32'($signed(i[31:20]));
      if (m inside {4, 5})        imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      if (m inside {7, 14})       imm = i & 32'hFFFF_F000;
      if (m == 6)                 imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      useA = m inside {1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};
      useB = m inside {2, 3, 4, 5, 11, 12, 13};
      s1 = useA ? i[19:15] : 5'd0;
      s2 = useB ? i[24:20] : 5'd0;

      e.imm = imm;
      e.ins = i;
      e.pc  = pc;
      e.oh  = 5'(m);
      e.ill = (m == 0);
      e.op1 = useA ? rf[s1] : (m inside {6, 14}) ? pc : 32'h0;
      e.op2 = useB ? rf[s2] : imm;
      if (m == 0) e.op2 = 0;
      e.rd  = (m == 0 || m == 4 || m == 5) ? 5'd0 : i[11:7];
      e.wen = (e.rd != 0);
   endfunction

   function automatic logic model_haz(input logic [4:0] s1, input logic [4:0] s2);
      model_haz = 1'b0;
      for (int k = 0; k < CHK; k++)
         if (msb[k] != 0 && (msb[k] == s1 || msb[k] == s2)) model_haz = 1'b1;
   endfunction

   // one clock of stimulus; called just after a rising edge
   task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic fl, output logic fired);
      exp_t e;
      logic [4:0] s1, s2;
      logic rdy;
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      bus.in_valid  = iv;
      bus.ins       = ins;
      bus.ins_addr  = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(negedge clk);
      ref_decode(ins, bus.ins_addr, e, s1, s2);
      rdy = (!mv || ordy) && !model_haz(s1, s2) && !fl;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
      if (iv) begin
         chk("rs1_addr", {27'd0, bus.rs1_addr}, {27'd0, s1});
         chk("rs2_addr", {27'd0, bus.rs2_addr}, {27'd0, s2});
      end
      fired = iv && rdy;
      @(posedge clk);
      if (ordy) begin
         for (int k = HAZ_DEPTH - 1; k > 0; k--) msb[k] = msb[k-1];
         msb[0] = (fired && e.wen) ? e.rd : 5'd0;
      end else if (fired && e.wen) begin
         msb[0] = e.rd;
      end
      mv = fl ? 1'b0 : fired ? 1'b1 : ordy ? 1'b0 : mv;
      if (fired) q.push_back(e);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_op1", bus.op1, 0);
      chk("rst_op2", bus.op2, 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_ins2ex", bus.ins2ex, 0);
      chk("rst_pc_out", bus.pc_out, 0);
      chk("rst_fields", {20'd0, bus.rd_addr, bus.rd_wen, bus.oh, bus.illegal}, 0);
      q.delete();
      for (int k = 0; k < HAZ_DEPTH; k++) msb[k] = 5'd0;
      mv = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // monitor: compares whatever ex takes; drops ops killed by flush
   always @(negedge clk) begin : mon
      exp_t a;
      if (!rst) begin
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (q.size() > 0)});
         if (bus.out_valid && q.size() > 0) begin
            if (bus.out_ready) begin
               a.op1 = bus.op1;    a.op2 = bus.op2;   a.imm = bus.imm;
               a.ins = bus.ins2ex; a.pc  = bus.pc_out; a.rd  = bus.rd_addr;
               a.wen = bus.rd_wen; a.oh  = bus.oh;     a.ill = bus.illegal;
               n_chk++;
               if (a === q[0]) n_pass++;
               else $display("FAIL out_op: got %h expected %h", a, q[0]);
               void'(q.pop_front());
            end else if (bus.flush) begin
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic f;
      int stalls;
      logic [31:0] ri;
      for (int k = 0; k < 32; k++) rf[k] = 32'h0;
      for (int k = 0; k < HAZ_DEPTH; k++) msb[k] = 5'd0;
      bus.in_valid = 0; bus.ins = 0; bus.ins_addr = 0; bus.out_ready = 0; bus.flush = 0;
      #2 do_reset();

      // ADDI x1,x0,5
      step(1, 32'h0050_0093, 1, 0, f);
      chk("addi_fire", {31'd0, f}, 1);
      chk("addi_vld", {31'd0, bus.out_valid}, 1);
      chk("addi_oh", {27'd0, bus.oh}, 1);
      chk("addi_op2", bus.op2, 5);
      chk("addi_rd", {26'd0, bus.rd_addr, bus.rd_wen}, {26'd0, 5'd1, 1'b1});

      // ADD x3,x1,x2 right behind it
      stalls = 0;
      for (int n = 0; n < 10; n++) begin
         step(1, 32'h0020_81B3, 1, 0, f);
         if (f) break;
         stalls++;
      end
      chk("raw_stall_cycles", stalls, CHK);

      // SUB x4,x3,x1 then hold with out_ready=0
      for (int n = 0; n < 10; n++) begin
         step(1, 32'h4011_8233, 1, 0, f);
         if (f) break;
      end
      chk("sub_fire", {31'd0, f}, 1);
      for (int n = 0; n < 4; n++) begin
         step(1, 32'h0070_0293, 0, 0, f);
         chk("hold_fire", {31'd0, f}, 0);
         chk("hold_vld", {31'd0, bus.out_valid}, 1);
         chk("hold_oh", {27'd0, bus.oh}, 3);
      end
      step(1, 32'h0070_0293, 1, 0, f);
      chk("release_fire", {31'd0, f}, 1);
      chk("release_oh", {27'd0, bus.oh}, 1);

      // flush with a pending input and a valid output
      step(1, 32'h0010_0313, 0, 1, f);
      chk("flush_fire", {31'd0, f}, 0);
      chk("flush_vld", {31'd0, bus.out_valid}, 0);
      stalls = 0;
      for (int n = 0; n < 10; n++) begin
         step(1, 32'h0052_83B3, 1, 0, f);
         if (f) break;
         stalls++;
      end
      chk("flush_keeps_sb", stalls, CHK);

      // illegal word, then a write to x0
      step(1, 32'hFFFF_FFFF, 1, 0, f);
      chk("illegal_fire", {31'd0, f}, 1);
      chk("illegal_flags", {25'd0, bus.illegal, bus.oh, bus.rd_wen}, {25'd0, 1'b1, 5'd0, 1'b0});
      step(1, 32'h0010_0013, 1, 0, f);
      chk("x0_wen", {26'd0, bus.oh, bus.rd_wen}, {26'd0, 5'd1, 1'b0});

      // reset in the middle of a stall
      step(1, 32'h0050_0093, 1, 0, f);
      step(1, 32'h0020_81B3, 1, 0, f);
      chk("pre_rst_stall", {31'd0, f}, 0);
      do_reset();
      step(1, 32'h0020_81B3, 1, 0, f);
      chk("post_rst_fire", {31'd0, f}, 1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         ri = $urandom;
         case ($urandom_range(0, 9))
            0, 1, 2: begin ri[6:0] = 7'h13; ri[11:7] = 5'($urandom_range(0, 4)); ri[19:15] = 5'($urandom_range(0, 4)); end
            3, 4: begin
               ri[6:0] = 7'h33; ri[11:7] = 5'($urandom_range(0, 4));
               ri[19:15] = 5'($urandom_range(0, 4)); ri[24:20] = 5'($urandom_range(0, 4));
               ri[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : ($urandom_range(0, 7) == 0) ? ri[31:25] : 7'h00;
            end
            5: begin
               ri[6:0] = 7'h63; ri[14:12] = 3'($urandom_range(0, 2));
               ri[19:15] = 5'($urandom_range(0, 4)); ri[24:20] = 5'($urandom_range(0, 4));
            end
            6: begin ri[6:0] = 7'h37; ri[11:7] = 5'($urandom_range(0, 4)); end
            7: begin ri[6:0] = 7'h17; ri[11:7] = 5'($urandom_range(0, 4)); end
            8: begin ri[6:0] = 7'h6f; ri[11:7] = 5'($urandom_range(0, 4)); end
            default: if ($urandom_range(0, 1) == 0) ri = 32'hFFFF_FFFF;
         endcase
         step($urandom_range(0, 9) < 8, ri, $urandom_range(0, 3) != 0,
              $urandom_range(0, 19) == 0, f);
      end

      // drain
      for (int n = 0; n < 4; n++) step(0, 32'h0, 1, 0, f);
      chk("drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
